// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between an instruction
// requester and a data requester. One transaction is outstanding at a time.
// Data wins by default; a starvation counter forces an inst grant after
// STARVE_LIMIT consecutive data grants won over a pending inst request.
//
// Handshake: a requester's *_sram_req is accepted in the cycle its
// *_sram_addr_ok is 1 (only possible while IDLE). The response is returned
// in the cycle its *_sram_data_ok is 1, with *_sram_rdata valid in that
// cycle only. On the memory side, mem_req is held with stable fields until
// the cycle mem_addr_ok is 1; the response is taken in the cycle
// mem_data_ok is 1.
module sram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction side
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // data side
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   // status
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

   state_t      state_q;
   logic [3:0]  starve_cnt_q;
   logic        owner_q;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [3:0]  wstrb_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic grant;
   logic grant_data;

   // Grant decision: data first unless inst has been passed over STARVE_LIMIT times.
   always_comb begin
      grant      = resetn && (state_q == IDLE) && (inst_sram_req || data_sram_req);
      grant_data = data_sram_req;
      if (inst_sram_req && (LIMIT_C != 4'd0) && (starve_cnt_q == LIMIT_C)) begin
         grant_data = 1'b0;
      end
   end

   // FSM, request latch, starvation counter and response capture.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         owner_q      <= 1'b0;
         wr_q         <= 1'b0;
         size_q       <= 2'd0;
         wstrb_q      <= 4'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  owner_q <= grant_data;
                  state_q <= ADDR;
                  if (grant_data) begin
                     wr_q    <= data_sram_wr;
                     size_q  <= data_sram_size;
                     wstrb_q <= data_sram_wstrb;
                     addr_q  <= data_sram_addr;
                     wdata_q <= data_sram_wdata;
                     // count only data wins that actually pass over a waiting inst
                     if (inst_sram_req && (starve_cnt_q != LIMIT_C)) begin
                        starve_cnt_q <= starve_cnt_q + 4'd1;
                     end
                  end else begin
                     wr_q         <= inst_sram_wr;
                     size_q       <= inst_sram_size;
                     wstrb_q      <= inst_sram_wstrb;
                     addr_q       <= inst_sram_addr;
                     wdata_q      <= inst_sram_wdata;
                     starve_cnt_q <= 4'd0;
                  end
               end
            end
            ADDR: begin
               if (mem_addr_ok) begin
                  if (mem_data_ok) begin
                     rdata_q <= wr_q ? 32'd0 : mem_rdata;
                     state_q <= RESP;
                  end else begin
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (mem_data_ok) begin
                  rdata_q <= wr_q ? 32'd0 : mem_rdata;
                  state_q <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Requester-facing outputs; only the owner sees data_ok and rdata.
   always_comb begin
      inst_sram_addr_ok = grant && !grant_data;
      data_sram_addr_ok = grant && grant_data;
      inst_sram_data_ok = (state_q == RESP) && !owner_q;
      data_sram_data_ok = (state_q == RESP) && owner_q;
      inst_sram_rdata   = inst_sram_data_ok ? rdata_q : 32'd0;
      data_sram_rdata   = data_sram_data_ok ? rdata_q : 32'd0;
   end

   // Memory-facing outputs come straight from the latched request.
   always_comb begin
      mem_req   = (state_q == ADDR);
      mem_wr    = wr_q;
      mem_size  = size_q;
      mem_wstrb = wstrb_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = (state_q != IDLE);
      owner     = owner_q;
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter. Inputs change on the falling edge and
// outputs are checked 1ns later. A second instance with STARVE_LIMIT=0
// shares all inputs and is compared only for grant order.
module tb_sram_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;
   logic        busy, owner;

   // outputs of the STARVE_LIMIT=0 instance
   logic        z_inst_addr_ok, z_inst_data_ok, z_data_addr_ok, z_data_data_ok;
   logic [31:0] z_inst_rdata, z_data_rdata;
   logic        z_mem_req, z_mem_wr;
   logic [1:0]  z_mem_size;
   logic [3:0]  z_mem_wstrb;
   logic [31:0] z_mem_addr, z_mem_wdata;
   logic        z_busy, z_owner;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   sram_arbiter #(.STARVE_LIMIT(2)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   sram_arbiter #(.STARVE_LIMIT(0)) dut0 (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(z_inst_addr_ok), .inst_sram_data_ok(z_inst_data_ok),
      .inst_sram_rdata(z_inst_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(z_data_addr_ok), .data_sram_data_ok(z_data_data_ok),
      .data_sram_rdata(z_data_rdata),
      .mem_req(z_mem_req), .mem_wr(z_mem_wr), .mem_size(z_mem_size), .mem_wstrb(z_mem_wstrb),
      .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .busy(z_busy), .owner(z_owner)
   );

   // clock: 10ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance to the next falling edge (inputs are driven there)
   task automatic cyc();
      @(negedge clk);
   endtask

   logic [5:0] seq2, seq0;
   int         n2, n0;

   initial begin
      resetn = 1'b0;
      inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
      inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
      data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
      data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
      seq2 = 6'd0; seq0 = 6'd0; n2 = 0; n0 = 0;

      // ---- reset: outputs stay 0 even with a request asserted
      cyc();
      cyc();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2;
      #1;
      chk1("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);

      // ---- single inst read, minimum latency
      cyc(); resetn = 1'b1; #1;                                    // T
      chk1("t1_inst_addr_ok_T", inst_sram_addr_ok, 1'b1);
      chk1("t1_data_addr_ok_T", data_sram_addr_ok, 1'b0);
      chk1("t1_busy_T", busy, 1'b0);
      cyc(); inst_sram_req = 1'b0; mem_addr_ok = 1'b1; #1;        // T+1
      chk1("t1_busy_T1", busy, 1'b1);
      chk1("t1_mem_req_T1", mem_req, 1'b1);
      chk32("t1_mem_addr", mem_addr, 32'h1c000000);
      chk32("t1_mem_size", 32'(mem_size), 32'd2);
      chk1("t1_owner", owner, 1'b0);
      cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h02c00000; #1; // T+2
      chk1("t1_mem_req_T2", mem_req, 1'b0);
      chk1("t1_data_ok_T2", inst_sram_data_ok, 1'b0);
      cyc(); mem_data_ok = 1'b0; mem_rdata = 32'hdeadbeef; #1;    // T+3
      chk1("t1_inst_data_ok_T3", inst_sram_data_ok, 1'b1);
      chk32("t1_inst_rdata_T3", inst_sram_rdata, 32'h02c00000);
      chk1("t1_data_data_ok_T3", data_sram_data_ok, 1'b0);
      chk32("t1_data_rdata_T3", data_sram_rdata, 32'h0);
      chk1("t1_busy_T3", busy, 1'b1);
      cyc(); #1;                                                   // T+4
      chk1("t1_busy_T4", busy, 1'b0);
      chk1("t1_inst_data_ok_T4", inst_sram_data_ok, 1'b0);
      chk32("t1_inst_rdata_T4", inst_sram_rdata, 32'h0);

      // ---- simultaneous data write + inst read; addr_ok/data_ok same cycle
      cyc();
      data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
      data_sram_wstrb = 4'b0011; data_sram_addr = 32'h100; data_sram_wdata = 32'h1234abcd;
      inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_addr = 32'h1c000004;
      #1;
      chk1("t2_data_addr_ok", data_sram_addr_ok, 1'b1);
      chk1("t2_inst_addr_ok", inst_sram_addr_ok, 1'b0);
      cyc(); data_sram_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      mem_rdata = 32'hffffffff; #1;
      chk1("t2_mem_req", mem_req, 1'b1);
      chk1("t2_mem_wr", mem_wr, 1'b1);
      chk32("t2_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk32("t2_mem_addr", mem_addr, 32'h100);
      chk32("t2_mem_wdata", mem_wdata, 32'h1234abcd);
      chk1("t2_owner", owner, 1'b1);
      chk1("t2_inst_wait", inst_sram_addr_ok, 1'b0);
      cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b0; #1;          // RESP directly
      chk1("t2_data_data_ok", data_sram_data_ok, 1'b1);
      chk32("t2_data_rdata_wr", data_sram_rdata, 32'h0);
      chk1("t2_inst_data_ok", inst_sram_data_ok, 1'b0);
      chk1("t2_inst_wait_resp", inst_sram_addr_ok, 1'b0);
      cyc(); #1;                                                   // IDLE again
      chk1("t2_inst_granted", inst_sram_addr_ok, 1'b1);
      chk1("t2_data_data_ok_off", data_sram_data_ok, 1'b0);
      cyc(); inst_sram_req = 1'b0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      mem_rdata = 32'hcafef00d; #1;
      chk1("t2_owner_inst", owner, 1'b0);
      chk32("t2_mem_addr_inst", mem_addr, 32'h1c000004);
      chk1("t2_mem_wr_inst", mem_wr, 1'b0);
      cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b0; #1;
      chk1("t2_inst_data_ok", inst_sram_data_ok, 1'b1);
      chk32("t2_inst_rdata", inst_sram_rdata, 32'hcafef00d);

      // ---- mem_addr_ok delayed 5 cycles, held request must not re-grant
      cyc();
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h200;
      data_sram_wstrb = 4'b0000; #1;
      chk1("t3_data_addr_ok", data_sram_addr_ok, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(); data_sram_addr = 32'h300; #1;
         chk1("t3_wait_mem_req", mem_req, 1'b1);
         chk32("t3_wait_mem_addr", mem_addr, 32'h200);
         chk1("t3_wait_addr_ok", data_sram_addr_ok, 1'b0);
      end
      cyc(); mem_addr_ok = 1'b1; #1;
      chk1("t3_mem_req_hs", mem_req, 1'b1);
      cyc(); mem_addr_ok = 1'b1; data_sram_req = 1'b0; #1;        // DATA, stray addr_ok
      chk1("t3_mem_req_data", mem_req, 1'b0);
      chk1("t3_busy_data", busy, 1'b1);
      cyc(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55aa55aa; #1;
      chk1("t3_still_data", data_sram_data_ok, 1'b0);
      cyc(); mem_data_ok = 1'b0; #1;
      chk1("t3_data_data_ok", data_sram_data_ok, 1'b1);
      chk32("t3_data_rdata", data_sram_rdata, 32'h55aa55aa);
      chk32("t3_inst_rdata", inst_sram_rdata, 32'h0);

      // ---- reset while in DATA, then stray mem_data_ok
      cyc();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1c00000c; inst_sram_wstrb = 4'hf; #1;
      chk1("t4_inst_addr_ok", inst_sram_addr_ok, 1'b1);
      cyc(); inst_sram_req = 1'b0; mem_addr_ok = 1'b1;
      cyc(); mem_addr_ok = 1'b0; resetn = 1'b0; #1;
      chk1("t4_busy_in_data", busy, 1'b1);
      cyc(); resetn = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h12345678; #1;
      chk1("t4_busy_after_rst", busy, 1'b0);
      chk1("t4_mem_req", mem_req, 1'b0);
      chk32("t4_mem_addr", mem_addr, 32'h0);
      chk32("t4_mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk1("t4_owner", owner, 1'b0);
      chk1("t4_inst_data_ok", inst_sram_data_ok, 1'b0);
      cyc(); mem_data_ok = 1'b0; #1;
      chk1("t4_inst_data_ok_late", inst_sram_data_ok, 1'b0);
      chk32("t4_inst_rdata_late", inst_sram_rdata, 32'h0);
      chk1("t4_busy_late", busy, 1'b0);

      // ---- starvation: both requesting, memory always ready (3 cycles/txn)
      cyc();
      inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b0;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (i != 0) cyc();
         #1;
         if (inst_sram_addr_ok || data_sram_addr_ok) begin
            seq2 = {seq2[4:0], data_sram_addr_ok};
            n2++;
         end
         if (z_inst_addr_ok || z_data_addr_ok) begin
            seq0 = {seq0[4:0], z_data_addr_ok};
            n0++;
         end
      end
      chk32("t5_lim2_grants", 32'(n2), 32'd6);
      chk32("t5_lim2_order", 32'(seq2), 32'b110110);
      chk32("t5_lim0_grants", 32'(n0), 32'd6);
      chk32("t5_lim0_order", 32'(seq0), 32'b111111);
      cyc(); inst_sram_req = 1'b0; data_sram_req = 1'b0;
      cyc();
      cyc();
      cyc(); #1;
      chk1("t5_drained", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
